// File: rtl/space_pkg.sv
// Shared types and screen geometry for the space game datapath.
package space_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'b001,
    StFly     = 3'b010,
    StExplode = 3'b100
  } laser_state_e;

  localparam logic [9:0] ScreenLeft   = 10'd8;
  localparam logic [9:0] ScreenRight  = 10'd631;
  localparam logic [9:0] ScreenTop    = 10'd8;
  localparam logic [9:0] ScreenWidth  = 10'd640;
  localparam logic [9:0] ScreenHeight = 10'd480;

endpackage

// File: rtl/counter.sv
// Wrapping event counter: counts enabled cycles 0..max_i, flags the enabled cycle at max_i.
module counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] max_i,
  output logic             wrap_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= (count_q == max_i) ? '0 : count_q + 1'b1;
    end
  end

  assign wrap_o = en_i && (count_q == max_i);

endmodule

// File: rtl/rising_edge_detect.sv
// Rising-edge detector: one history flop, pulse while input is high and was low last cycle.
module rising_edge_detect (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic edge_o
);

  logic d_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign edge_o = d_i & ~d_q;

endmodule

// File: rtl/player_laser.sv
// Player laser: spawns on a fire press, climbs one step per tick group, retires at the
// top border or explodes on an enemy hit.
module player_laser
  import space_pkg::*;
#(
  parameter logic [11:0] color_p      = 12'hFFF,
  parameter logic [9:0]  start_y_p    = 10'd440,
  parameter logic [9:0]  top_border_p = ScreenTop,
  parameter logic [9:0]  step_p       = 10'd4,
  parameter logic [3:0]  tick_div_p   = 4'd2,
  parameter logic [3:0]  explode_p    = 4'd8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_tick_i,
  input  logic       fire_i,
  input  logic [9:0] gun_pos_i,
  input  logic       alive_i,
  input  logic       freeze_i,
  input  logic       hit_enemy_i,
  output logic [9:0] laser_x_o,
  output logic [9:0] laser_y_o,
  output logic       active_o,
  output logic       explode_o,
  output logic       shot_o,
  output logic       kill_o,
  output logic [3:0] laser_red_o,
  output logic [3:0] laser_green_o,
  output logic [3:0] laser_blue_o,
  output logic [2:0] state_o
);

  // Compare against border+step before subtracting so y can never wrap below zero.
  localparam logic [9:0] RetireBelow = top_border_p + step_p;

  laser_state_e state_q, state_d;
  logic [9:0]   x_q, x_d, y_q, y_d;
  logic         active_d, explode_d, shot_d, kill_d;
  logic         fire_edge, spawn, hit, advance, retire;
  logic         tick_en, expl_en, expl_wrap;

  rising_edge_detect u_fire_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .d_i     (fire_i),
    .edge_o  (fire_edge)
  );

  assign tick_en = (state_q == StFly) && alive_i && !hit_enemy_i && !freeze_i && frame_tick_i;
  assign expl_en = (state_q == StExplode) && alive_i && !freeze_i && frame_tick_i;

  counter #(.Width(4)) u_tick_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (state_q != StFly),
    .en_i    (tick_en),
    .max_i   (tick_div_p - 4'd1),
    .wrap_o  (advance)
  );

  counter #(.Width(4)) u_expl_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (state_q != StExplode),
    .en_i    (expl_en),
    .max_i   (explode_p - 4'd1),
    .wrap_o  (expl_wrap)
  );

  assign spawn  = (state_q == StIdle) && fire_edge && alive_i && !freeze_i;
  assign hit    = (state_q == StFly) && alive_i && hit_enemy_i;
  assign retire = advance && (y_q < RetireBelow);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (spawn) state_d = StFly;
      StFly: begin
        if (!alive_i)    state_d = StIdle;
        else if (hit)    state_d = StExplode;
        else if (retire) state_d = StIdle;
      end
      StExplode: if (!alive_i || expl_wrap) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (spawn) begin
      x_d = gun_pos_i;
      y_d = start_y_p;
    end else if (advance && !retire) begin
      y_d = y_q - step_p;
    end
  end

  always_comb begin
    shot_d    = spawn;
    kill_d    = hit;
    active_d  = (state_d == StFly);
    explode_d = (state_d == StExplode);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_q       <= '0;
      y_q       <= start_y_p;
      active_o  <= 1'b0;
      explode_o <= 1'b0;
      shot_o    <= 1'b0;
      kill_o    <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      active_o  <= active_d;
      explode_o <= explode_d;
      shot_o    <= shot_d;
      kill_o    <= kill_d;
    end
  end

  assign laser_x_o     = x_q;
  assign laser_y_o     = y_q;
  assign state_o       = state_q;
  assign laser_red_o   = color_p[11:8];
  assign laser_green_o = color_p[7:4];
  assign laser_blue_o  = color_p[3:0];

endmodule
